// File: rtl/reg_file_wb_pkg.sv
// Shared constants and helpers for the write-back register file.
// Address width, register count, zero-register index and write-counter limits.
package reg_file_wb_pkg;

  localparam int ADDR_W         = 5;
  localparam int NREG_DEFAULT   = 32;
  localparam int DATA_W_DEFAULT = 32;
  localparam int WCNT_W         = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [WCNT_W-1:0] WCNT_MAX = 16'hFFFF;

  // Saturating increment: the counter parks at WCNT_MAX instead of wrapping.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] cnt,
                                                input logic              inc);
    logic [WCNT_W-1:0] res;
    res = cnt;
    if (inc && (cnt != WCNT_MAX)) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_wb_dec5to32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when the enable is low,
// so an undefined address with the enable deasserted produces no strobe.
module dec5to32
  import reg_file_wb_pkg::*;
#(
  parameter int NOUT = NREG_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NOUT-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back register file: 32 x DATA_W, register 0 hard-wired to zero, two
// combinational read ports, written-since-reset flags and a saturating write
// counter. Define WRITE_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int NREG   = NREG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] OA,
  output logic [DATA_W-1:0] OB,
  output logic              VA,
  output logic              VB,
  output logic [WCNT_W-1:0] wcnt
);

  logic                         wr_commit;
  logic [NREG-1:0]              wr_en;

  logic [NREG-1:0][DATA_W-1:0]  regs_q;
  logic [NREG-1:0][DATA_W-1:0]  regs_d;
  logic [NREG-1:0]              flag_q;
  logic [NREG-1:0]              flag_d;
  logic [WCNT_W-1:0]            wcnt_q;
  logic [WCNT_W-1:0]            wcnt_d;

  logic [DATA_W-1:0]            rd_a_data;
  logic [DATA_W-1:0]            rd_b_data;
  logic                         rd_a_valid;
  logic                         rd_b_valid;

  // Writes to register 0 are dropped before decode, so they neither store
  // data nor count towards wcnt.
  assign wr_commit = we & (WA != ZERO_REG);

  dec5to32 #(
    .NOUT (NREG)
  ) u_dec (
    .addr   (WA),
    .en     (wr_commit),
    .onehot (wr_en)
  );

  always_comb begin
    regs_d = regs_q;
    flag_d = flag_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en[i]) begin
        regs_d[i] = WD;
        flag_d[i] = 1'b1;
      end
    end
    wcnt_d = sat_inc(wcnt_q, wr_commit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      flag_q <= '0;
      wcnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      flag_q <= flag_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Committed-state reads; address 0 always reads as a valid zero.
  always_comb begin
    rd_a_data  = '0;
    rd_b_data  = '0;
    rd_a_valid = 1'b1;
    rd_b_valid = 1'b1;
    if (RA != ZERO_REG) begin
      rd_a_data  = regs_q[RA];
      rd_a_valid = flag_q[RA];
    end
    if (RB != ZERO_REG) begin
      rd_b_data  = regs_q[RB];
      rd_b_valid = flag_q[RB];
    end
  end

`ifdef WRITE_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // wr_commit already excludes WA=0, so register 0 is never forwarded.
  assign byp_a = wr_commit & (RA == WA);
  assign byp_b = wr_commit & (RB == WA);

  assign OA = byp_a ? WD : rd_a_data;
  assign OB = byp_b ? WD : rd_b_data;
  assign VA = byp_a | rd_a_valid;
  assign VB = byp_b | rd_b_valid;
`else
  assign OA = rd_a_data;
  assign OB = rd_b_data;
  assign VA = rd_a_valid;
  assign VB = rd_b_valid;
`endif

  assign wcnt = wcnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed vector table, reset corner
// cases, randomized traffic against an array-based model, and counter saturation.
module tb_reg_file_wb;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [31:0] OA;
  logic [31:0] OB;
  logic        VA;
  logic        VB;
  logic [15:0] wcnt;

  int checks;
  int errors;

  logic [31:0] m_reg  [32];
  bit          m_flag [32];
  int          m_cnt;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_oa;
    logic        exp_va;
    logic [31:0] exp_ob;
    logic        exp_vb;
    logic [15:0] exp_wcnt;
  } vec_t;

  vec_t vecs [8];

  reg_file_wb dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .WA   (WA),
    .WD   (WD),
    .RA   (RA),
    .RB   (RB),
    .OA   (OA),
    .OB   (OB),
    .VA   (VA),
    .VB   (VB),
    .wcnt (wcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb);
    we = w;
    WA = wa;
    WD = wd;
    RA = ra;
    RB = rb;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_flag[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic modelCommit(input logic w, input logic [4:0] wa, input logic [31:0] wd);
    if (w && wa != 0) begin
      m_reg[wa]  = wd;
      m_flag[wa] = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic modelRead(input logic [4:0] ra, input logic w, input logic [4:0] wa,
                           input logic [31:0] wd, output logic [31:0] data, output logic valid);
    if (ra == 0) begin
      data  = '0;
      valid = 1'b1;
    end else if (BYP && w && wa == ra) begin
      data  = wd;
      valid = 1'b1;
    end else begin
      data  = m_reg[ra];
      valid = m_flag[ra];
    end
  endtask

  task automatic checkAgainstModel(input string tag);
    logic [31:0] ea, eb;
    logic        va_e, vb_e;
    modelRead(RA, we, WA, WD, ea, va_e);
    modelRead(RB, we, WA, WD, eb, vb_e);
    checkOutput({tag, "_OA"}, OA, ea);
    checkOutput({tag, "_VA"}, {31'b0, VA}, {31'b0, va_e});
    checkOutput({tag, "_OB"}, OB, eb);
    checkOutput({tag, "_VB"}, {31'b0, VB}, {31'b0, vb_e});
    checkOutput({tag, "_wcnt"}, {16'b0, wcnt}, m_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelReset();

    vecs[0] = '{1'b1, 5'd3,  32'd5,          5'd3, 5'd5,  BYP ? 32'd5 : 32'd0,            BYP,  32'd0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 5'd0,  32'd0,          5'd3, 5'd5,  32'd5,                          1'b1, 32'd0, 1'b0, 16'd1};
    vecs[2] = '{1'b1, 5'd0,  32'h0000DEAD,   5'd0, 5'd3,  32'd0,                          1'b1, 32'd5, 1'b1, 16'd1};
    vecs[3] = '{1'b0, 5'd0,  32'd0,          5'd0, 5'd0,  32'd0,                          1'b1, 32'd0, 1'b1, 16'd1};
    vecs[4] = '{1'b1, 5'd7,  32'd9,          5'd7, 5'd7,  BYP ? 32'd9 : 32'd0,            BYP,  BYP ? 32'd9 : 32'd0, BYP, 16'd1};
    vecs[5] = '{1'b0, 5'd0,  32'd0,          5'd7, 5'd3,  32'd9,                          1'b1, 32'd5, 1'b1, 16'd2};
    vecs[6] = '{1'b1, 5'd3,  32'h0000AAAA,   5'd3, 5'd7,  BYP ? 32'h0000AAAA : 32'd5,     1'b1, 32'd9, 1'b1, 16'd2};
    vecs[7] = '{1'b0, 5'd0,  32'd0,          5'd3, 5'd31, 32'h0000AAAA,                   1'b1, 32'd0, 1'b0, 16'd3};

    // Reset held with an active write pending on the bus.
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
    #99;
    checkOutput("rst_OA",   OA, 32'd0);
    checkOutput("rst_OB",   OB, 32'd0);
    checkOutput("rst_VA",   {31'b0, VA}, 32'd0);
    checkOutput("rst_VB",   {31'b0, VB}, 32'd0);
    checkOutput("rst_wcnt", {16'b0, wcnt}, 32'd0);
    RA = 5'd0;
    #1;
    checkOutput("rst_VA_r0", {31'b0, VA}, 32'd1);
    we  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vector table: checked before the edge, then committed.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      #2;
      checkOutput($sformatf("vec%0d_OA", i),   OA, vecs[i].exp_oa);
      checkOutput($sformatf("vec%0d_VA", i),   {31'b0, VA}, {31'b0, vecs[i].exp_va});
      checkOutput($sformatf("vec%0d_OB", i),   OB, vecs[i].exp_ob);
      checkOutput($sformatf("vec%0d_VB", i),   {31'b0, VB}, {31'b0, vecs[i].exp_vb});
      checkOutput($sformatf("vec%0d_wcnt", i), {16'b0, wcnt}, {16'b0, vecs[i].exp_wcnt});
      @(posedge clk);
      #1;
      modelCommit(vecs[i].we, vecs[i].wa, vecs[i].wd);
    end

    // Asynchronous reset between edges while a write to r3 is pending.
    applyStimulus(1'b1, 5'd3, 32'd8, 5'd3, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_OA",   OA, 32'd0);
    checkOutput("arst_VA",   {31'b0, VA}, 32'd0);
    checkOutput("arst_OB",   OB, 32'd0);
    checkOutput("arst_wcnt", {16'b0, wcnt}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("arst_edge_OA",   OA, 32'd0);
    checkOutput("arst_edge_wcnt", {16'b0, wcnt}, 32'd0);
    applyStimulus(1'b0, 5'd3, 32'd8, 5'd3, 5'd7);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("arst_post_OA",   OA, 32'd0);
    checkOutput("arst_post_VA",   {31'b0, VA}, 32'd0);
    checkOutput("arst_post_wcnt", {16'b0, wcnt}, 32'd0);
    modelReset();

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      logic        w;
      logic [4:0]  wa, ra, rb;
      logic [31:0] wd;
      w  = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(w, wa, wd, ra, rb);
      #2;
      checkAgainstModel($sformatf("rnd%0d", n));
      @(posedge clk);
      #1;
      modelCommit(w, wa, wd);
    end

    // Saturation: 65535 writes reach WCNT_MAX, further writes still store data.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 5'd1, 32'd0, 5'd1, 5'd0);
    for (int i = 0; i < 65535; i++) begin
      WD = 32'(i);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    #1;
    checkOutput("sat_wcnt_max", {16'b0, wcnt}, 32'h0000FFFF);
    checkOutput("sat_OA_last",  OA, 32'd65534);
    applyStimulus(1'b1, 5'd1, 32'hCAFE0001, 5'd1, 5'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'd1, 32'hCAFE0002, 5'd1, 5'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    #1;
    checkOutput("sat_wcnt_hold", {16'b0, wcnt}, 32'h0000FFFF);
    checkOutput("sat_OA_upd",    OA, 32'hCAFE0002);
    checkOutput("sat_VA",        {31'b0, VA}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Write-back destination end of the 5-bit register-address path.
- Takes the 5-bit destination address selected upstream, decodes it one-hot and commits write data into a 32-entry register file.
- Serves two combinational read ports to the operand stage.
- Tracks a per-register written-since-reset flag so the control unit can detect reads of never-written registers.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- NREG, 32, number of registers; fixed by the 5-bit address, must equal 2**5.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable for the current cycle.
- WA  input  5  write address (destination register from the 5-bit address mux).
- WD  input  DATA_W  write data.
- RA  input  5  read address, port A.
- RB  input  5  read address, port B.
- OA  output  DATA_W  read data, port A.
- OB  output  DATA_W  read data, port B.
- VA  output  1  register at RA has been written since reset (always 1 for RA=0).
- VB  output  1  same for RB.
- wcnt  output  16  number of committed writes since reset, saturating.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - all registers = 0, all written flags = 0, wcnt = 0.
  - OA/OB = 0, VA/VB = 1 only for address 0, 0 otherwise.
- Write decode: WA is decoded to a 32-bit one-hot enable gated by we; exactly one or zero enables are active per cycle.
- Commit:
  - On rising clk with we=1 and WA!=0, reg[WA] <= WD and flag[WA] <= 1.
  - Visible on OA/OB from the following cycle, so write-to-read latency is 1 clock.
- Register 0:
  - Writes to WA=0 are discarded; no state change, wcnt not incremented.
  - OA/OB for address 0 are always 0.
- Reads:
  - Purely combinational from the current register contents.
  - RA==RB is legal; both ports return the same value.
- wcnt:
  - Increments by 1 on each committed write (we=1, WA!=0).
  - Saturates at 16'hFFFF, with no wrap-around.
- Simultaneous write and read of the same address (without the optional feature): the read returns the old value in that cycle and the new value the next cycle.
- Reset asserted mid-operation overrides any write in that cycle; no partial commit.
- X/undefined WA while we=0 has no effect.

Optional Feature:
- Macro WRITE_BYPASS_EN.
- Defined: if we=1, WA!=0 and RA==WA, then OA=WD and VA=1 in the same cycle; identical rule for RB/OB/VB. Address 0 is never bypassed.
- Undefined: no forwarding; reads see only committed state, as described under Behaviour.
- wcnt and register contents are identical in both builds.

Decomposition:
- Shared package/header:
  - ADDR_W=5, NREG=32, DATA_W default.
  - ZERO_REG=5'd0.
  - WCNT_MAX=16'hFFFF.
- Sub-module dec5to32:
  - 5-bit address plus enable in, 32-bit one-hot out.
  - All zeros when the enable is low.
  - Reused by the write port and the flag update.

Test Plan:
- Reset: assert rst for 100 ns with WD=32'hFFFFFFFF, we=1 -> OA=OB=0, VA=VB=0 (RA=RB=3), wcnt=0.
- Basic write/read: WA=3, WD=5, we=1 for 1 clk, then RA=3, RB=5 -> OA=5, VA=1, OB=0, VB=0, wcnt=1.
- Register 0: WA=0, WD=32'hDEAD, we=1 for 1 clk, RA=0 -> OA=0, VA=1, wcnt unchanged.
- Same-cycle hazard: WA=7, WD=9, RA=7, we=1 -> OA=old value (0) without the macro and 9 with WRITE_BYPASS_EN; after the edge OA=9 in both builds.
- Async reset mid-write: reg[3]=5, then assert rst between clock edges while we=1, WA=3, WD=8 -> OA(RA=3)=0 immediately, wcnt=0, and after release 0 is still held.
- Saturation: force 65536 committed writes to WA=1 -> wcnt stops at 16'hFFFF; a further write keeps wcnt=16'hFFFF while the data still updates.
